// File: rtl/pingpong_buffer_ctrl.sv
// Ping-pong controller for the dual-port audio RAM: tracks the two half-buffer
// full flags and the write/read half selects, and sequences playback states.
module pingpong_buffer_ctrl #(
    parameter int              BUFFER_ADDR_BITS = 9,
    parameter logic [15:0]     UNDERRUN_MAX     = 16'hFFFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          pause_i,
    input  logic                          eos_i,
    input  logic                          wr_en_i,
    input  logic [BUFFER_ADDR_BITS-1:0]   wr_addr_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          wr_done_i,
    output logic                          wr_ready_o,
    input  logic [BUFFER_ADDR_BITS-1:0]   rd_addr_i,
    input  logic                          rd_release_i,
    output logic                          rd_active_o,
    output logic                          ram_wren_o,
    output logic [BUFFER_ADDR_BITS:0]     ram_wr_addr_o,
    output logic [7:0]                    ram_wr_data_o,
    output logic [BUFFER_ADDR_BITS:0]     ram_rd_addr_o,
    output logic [1:0]                    level_o,
    output logic [1:0]                    state_o,
    output logic                          underrun_o,
    output logic [15:0]                   underrun_count_o
);

    typedef enum logic [1:0] {
        ST_PRIME    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_PAUSE    = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  full_q, full_d;
    logic        wr_sel_q, wr_sel_d;
    logic        rd_sel_q, rd_sel_d;
    logic        rd_active_q, rd_active_d;
    logic        underrun_q, underrun_d;
    logic [15:0] count_q, count_d;

    logic        done_ok;
    logic        rel_ok;
    logic        rd_half_full;

    assign wr_ready_o       = ~full_q[wr_sel_q];
    // A flush discards any byte offered in the same cycle.
    assign ram_wren_o       = wr_en_i & wr_ready_o & ~flush_i;
    assign ram_wr_addr_o    = {wr_sel_q, wr_addr_i};
    assign ram_wr_data_o    = wr_data_i;
    assign ram_rd_addr_o    = {rd_sel_q, rd_addr_i};
    assign level_o          = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign state_o          = state_q;
    assign rd_active_o      = rd_active_q;
    assign underrun_o       = underrun_q;
    assign underrun_count_o = count_q;

    always_comb begin
        done_ok = wr_done_i & wr_ready_o;
        // Pause wins over a release arriving in the same cycle.
        rel_ok  = rd_release_i & rd_active_q & ~pause_i;

        full_d = full_q;
        if (done_ok) full_d[wr_sel_q] = 1'b1;
        if (rel_ok)  full_d[rd_sel_q] = 1'b0;
        wr_sel_d = wr_sel_q ^ done_ok;
        rd_sel_d = rd_sel_q ^ rel_ok;

        // Decisions look at the half the reader will own next cycle.
        rd_half_full = full_d[rd_sel_d];

        state_d    = state_q;
        underrun_d = 1'b0;
        count_d    = count_q;

        case (state_q)
            ST_PRIME: begin
                if ((full_d == 2'b11) || (rd_half_full && eos_i))
                    state_d = pause_i ? ST_PAUSE : ST_PLAY;
            end
            ST_PLAY: begin
                if (pause_i) begin
                    state_d = ST_PAUSE;
                end else if (rel_ok && !rd_half_full) begin
                    state_d    = ST_UNDERRUN;
                    underrun_d = 1'b1;
                    if (count_q != UNDERRUN_MAX) count_d = count_q + 16'd1;
                end
            end
            ST_UNDERRUN: begin
                if (pause_i)           state_d = ST_PAUSE;
                else if (rd_half_full) state_d = ST_PLAY;
            end
            ST_PAUSE: begin
                if (!pause_i) state_d = rd_half_full ? ST_PLAY : ST_UNDERRUN;
            end
            default: state_d = ST_PRIME;
        endcase

        if (flush_i) begin
            full_d     = 2'b00;
            wr_sel_d   = 1'b0;
            rd_sel_d   = 1'b0;
            state_d    = ST_PRIME;
            underrun_d = 1'b0;
            count_d    = count_q;
        end

        rd_active_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PRIME;
            full_q      <= 2'b00;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_active_q <= 1'b0;
            underrun_q  <= 1'b0;
            count_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            rd_active_q <= rd_active_d;
            underrun_q  <= underrun_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: doc/pingpong_buffer_ctrl.md
# pingpong_buffer_ctrl

Ping-pong controller for the dual-port audio RAM. It sits between the FAT32 reader, which writes the buffer, and the codec, which reads it. It owns the two half-buffer full flags and the write/read half selects, and it composes the RAM addresses from them. It sequences playback through prime, play, pause and underrun states, and counts underruns for the status LEDs and the logic analyzer.

## Interface
Parameters:
- BUFFER_ADDR_BITS, default 9: address width of one half (512 bytes = one SD block); the RAM address is BUFFER_ADDR_BITS+1 bits wide.

Ports:
- clk  in  1  system clock (200 MHz)
- rst  in  1  reset; asynchronous, active-high
- flush_i  in  1  one-cycle pulse: drop all buffered data (new song)
- pause_i  in  1  level: playback paused while high
- eos_i  in  1  level from writer: no further halves will follow
- wr_en_i  in  1  writer byte strobe
- wr_addr_i  in  BUFFER_ADDR_BITS  byte offset inside the write half
- wr_data_i  in  8  write byte
- wr_done_i  in  1  one-cycle pulse: current write half complete
- wr_ready_o  out  1  write half is free (= !full[wr_sel])
- rd_addr_i  in  BUFFER_ADDR_BITS  codec byte offset inside the read half
- rd_release_i  in  1  one-cycle pulse: codec finished the read half
- rd_active_o  out  1  codec may consume the read half
- ram_wren_o  out  1  RAM write enable
- ram_wr_addr_o  out  BUFFER_ADDR_BITS+1  {wr_sel, wr_addr_i}
- ram_wr_data_o  out  8  wr_data_i passthrough
- ram_rd_addr_o  out  BUFFER_ADDR_BITS+1  {rd_sel, rd_addr_i}
- level_o  out  2  number of full halves (0..2)
- state_o  out  2  PRIME=0, PLAY=1, PAUSE=2, UNDERRUN=3
- underrun_o  out  1  one-cycle pulse on entry to UNDERRUN
- underrun_count_o  out  16  saturating underrun counter

## Operation
- Registered internal state:
  - full[1:0]: one full flag per half
  - wr_sel, rd_sel: write and read half selects
  - state: controller state
  - underrun counter
- Write side:
  - ram_wren_o = wr_en_i & wr_ready_o (combinational). Bytes offered while wr_ready_o=0 are dropped.
  - wr_done_i with wr_ready_o=1: set full[wr_sel] and toggle wr_sel.
  - wr_done_i with wr_ready_o=0: ignored.
- Read side:
  - rd_release_i is accepted only while rd_active_o=1, otherwise ignored.
  - On acceptance: clear full[rd_sel] and toggle rd_sel.
- All state transitions use the next-cycle full flags, so a simultaneous wr_done_i is included.
- PRIME:
  - Exit when full==2'b11, or when full[rd_sel]=1 and eos_i=1.
  - Exit goes to PAUSE if pause_i=1, else to PLAY.
  - pause_i is otherwise ignored in PRIME.
- PLAY:
  - pause_i=1 → PAUSE. pause_i has priority over a simultaneous release, which is then not accepted.
  - Accepted release, and the new full[rd_sel]=0 → UNDERRUN.
- UNDERRUN:
  - full[rd_sel]=1 → PLAY.
  - pause_i=1 → PAUSE.
- PAUSE:
  - pause_i=0 → PLAY if full[rd_sel]=1, else UNDERRUN. This resume entry to UNDERRUN does not pulse or count.
- Underrun counting: entering UNDERRUN from PLAY pulses underrun_o and increments the counter. The counter saturates at 16'hFFFF.
- flush_i has the highest priority:
  - full=0, wr_sel=0, rd_sel=0, state=PRIME.
  - The underrun counter is kept.
  - Any write strobe or done in the same cycle is discarded.

## Timing
- Reset values: full=0, wr_sel=0, rd_sel=0, state=PRIME, rd_active_o=0, underrun_o=0, underrun_count_o=0, level_o=0, wr_ready_o=1.
- RAM outputs (ram_wren_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o) are combinational from the inputs and the registered selects; zero latency.
- rd_active_o = (state==PLAY), registered.
  - It rises in the cycle after the wr_done_i cycle that completes priming.
  - It falls in the cycle after a pause or an underrun.
- level_o, wr_ready_o and ram_rd_addr_o reflect a done or release in the following cycle.
- Simultaneous wr_done_i and accepted rd_release_i: both applied. If the writer fills the half the reader switches to, there is no underrun.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous reset); no partial state survives.

## Test plan
- Reset, then two wr_done_i pulses 10 cycles apart → level_o 0→1→2; rd_active_o=1 one cycle after the second pulse; state_o=1; ram_rd_addr_o MSB=0.
- Playing with full=11:
  - rd_release_i → next cycle rd_sel=1, level_o=1, ram_rd_addr_o MSB=1, wr_ready_o=1 with ram_wr_addr_o MSB=0.
  - Then write byte 8'hA5 at offset 3 → ram_wren_o=1, ram_wr_addr_o=10'h003.
- Underrun: with only one half full, rd_release_i → underrun_o pulse, count=1, state_o=3, rd_active_o=0. Then wr_done_i → state_o=1 next cycle.
- Same-cycle rd_release_i and wr_done_i onto the target half → no underrun_o, count unchanged, level_o unchanged.
- Pause during PLAY:
  - pause_i=1 → state_o=2, rd_active_o=0; rd_release_i pulses are ignored (level_o constant).
  - pause_i=0 → state_o=1.
- Edge cases:
  - eos_i=1 with one full half in PRIME → PLAY.
  - flush_i mid-PLAY with count=5 → state_o=0, level_o=0, count stays 5.
  - Forced 65 540 underruns → count holds at 16'hFFFF.
